// File: rtl/aes256_key_expand_pkg.sv
// aes256_key_expand_pkg: shared constants, state encoding and forward S-box for the AES-256 key schedule
package aes256_key_expand_pkg;

    localparam int AES_NR = 14;
    localparam int AES_NK = 8;
    localparam int KEY_W  = 32 * AES_NK;
    localparam int BLK_W  = 128;

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    // entry 0 is rc_1
    localparam logic [6:0][7:0] RCON = {8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    // byte 0 of the table sits in the most significant position
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TAB[{~x, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/aes256_key_word_sub.sv
// aes256_key_word_sub: forward S-box substitution applied bytewise to one 32-bit word
module aes256_key_word_sub
    import aes256_key_expand_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub_word
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign sub_word[8*i +: 8] = sbox(word[8*i +: 8]);
    end

endmodule

// File: rtl/aes256_key_expand.sv
// aes256_key_expand: expands a 256-bit key into 15 round keys, one per clock, and serves them
// forward or in reverse (decrypt) order from an internal buffer.
module aes256_key_expand
    import aes256_key_expand_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             key_ready,
    input  logic [3:0]       rd_round,
    input  logic             inv_en,
    output logic [BLK_W-1:0] round_key
);

    state_t           state;
    logic [3:0]       k;
    logic [BLK_W-1:0] key_buf [0:AES_NR];
    logic [BLK_W-1:0] p, q;
    logic [31:0]      rot, sub, t, n0, n1, n2, n3;
    logic [3:0]       idx;

    // even k starts a new 8-word group, which takes RotWord and Rcon
    assign p   = key_buf[k - 4'd1];
    assign q   = key_buf[k - 4'd2];
    assign rot = k[0] ? p[31:0] : {p[23:0], p[31:24]};

    aes256_key_word_sub u_sub (
        .word     (rot),
        .sub_word (sub)
    );

    assign t  = k[0] ? sub : sub ^ {RCON[k[3:1] - 3'd1], 24'h0};
    assign n0 = q[127:96] ^ t;
    assign n1 = q[95:64]  ^ n0;
    assign n2 = q[63:32]  ^ n1;
    assign n3 = q[31:0]   ^ n2;

    assign idx       = inv_en ? 4'(AES_NR) - rd_round : rd_round;
    assign round_key = (rd_round > 4'(AES_NR)) ? '0 : key_buf[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            busy      <= 1'b0;
            key_ready <= 1'b0;
            for (int i = 0; i <= AES_NR; i++) key_buf[i] <= '0;
        end else begin
            case (state)
                IDLE, READY: if (start) begin
                    key_buf[0] <= key_in[255:128];
                    key_buf[1] <= key_in[127:0];
                    k          <= 4'd2;
                    state      <= EXPAND;
                    busy       <= 1'b1;
                    key_ready  <= 1'b0;
                end
                EXPAND: begin
                    key_buf[k] <= {n0, n1, n2, n3};
                    k          <= k + 4'd1;
                    if (k == 4'(AES_NR)) begin
                        state     <= READY;
                        busy      <= 1'b0;
                        key_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes256_key_expand.sv
// tb_aes256_key_expand: scoreboard bench; a FIPS-197 style word-level key schedule model
// with an S-box derived from GF(2^8) inversion provides the expected round keys.
module tb_aes256_key_expand;

    logic         clk = 1'b0;
    logic         rst, start, busy, key_ready, inv_en;
    logic [255:0] key_in;
    logic [3:0]   rd_round;
    logic [127:0] round_key;

    typedef struct {
        logic [14:0][127:0] rk;
        int                 issue;
        bit                 zero;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] sb [256];
    int         cyc = 0, checks = 0, failures = 0, done_cnt = 0, probe_cnt = 0;

    aes256_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .key_ready (key_ready),
        .rd_round  (rd_round),
        .inv_en    (inv_en),
        .round_key (round_key)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= a;
            a = xtime(a);
        end
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [14:0][127:0] expand(input logic [255:0] key);
        logic [31:0]        w [60];
        logic [31:0]        t;
        logic [7:0]         rc;
        logic [14:0][127:0] rk;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [255:0] key, input int kat);
        exp_t e;
        e.rk    = expand(key);
        e.zero  = 1'b0;
        e.issue = cyc;
        if (kat == 1) begin
            e.rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
            e.rk[1]  = 128'h101112131415161718191a1b1c1d1e1f;
            e.rk[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
            e.rk[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
        end
        if (kat == 2) e.rk[2] = 128'h9ba354118e6925afa51a8b5f2067fcde;
        exp_q.push_back(e);
        key_in = key;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = rand256();
    endtask

    task automatic probe_zero();
        exp_t e;
        e.rk    = '0;
        e.zero  = 1'b1;
        e.issue = 0;
        exp_q.push_back(e);
        probe_cnt++;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("event_arrival", 128'(done_cnt), 128'(target));
    endtask

    // monitor: on each key_ready rise (or a requested post-reset probe) pop and sweep every read index
    initial begin : monitor
        exp_t e;
        logic prev;
        bit   ev, pr;
        int   probe_seen;
        prev       = 1'b0;
        probe_seen = 0;
        rd_round   = 4'd0;
        inv_en     = 1'b0;
        forever begin
            @(negedge clk);
            ev   = key_ready && !prev;
            pr   = probe_cnt != probe_seen;
            prev = key_ready;
            if (ev || pr) begin
                probe_seen = probe_cnt;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: ready=%0b probe=%0b with empty scoreboard", ev, pr);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 128'(pr), 128'(e.zero));
                    if (!e.zero) check("ready_latency", 128'(cyc - e.issue - 1), 128'd13);
                    for (int inv = 0; inv < 2; inv++) begin
                        for (int r = 0; r < 16; r++) begin
                            rd_round = 4'(r);
                            inv_en   = inv[0];
                            #1;
                            check($sformatf("rk inv=%0d rd=%0d", inv, r), round_key,
                                  (r > 14 || e.zero) ? 128'h0 : e.rk[inv != 0 ? 14 - r : r]);
                        end
                    end
                end
                done_cnt++;
            end
        end
    end

    initial begin : stim
        logic [7:0]   inv, s;
        logic [255:0] k1, k2;
        int           target;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
        end
        k1     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        k2     = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        target = 0;
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_ready", 128'(key_ready), 128'd0);
        probe_zero();
        wait_done(++target);
        issue(k1, 1);
        check("busy_after_start", 128'(busy), 128'd1);
        wait_done(++target);
        issue(k2, 2);
        wait_done(++target);
        // a second start mid-expansion must be ignored
        issue(k1, 1);
        repeat (4) @(negedge clk);
        check("busy_mid_expand", 128'(busy), 128'd1);
        start  = 1'b1;
        key_in = rand256();
        @(negedge clk);
        start = 1'b0;
        wait_done(++target);
        // asynchronous reset in the middle of an expansion
        issue(rand256(), 0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_ready", 128'(key_ready), 128'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        probe_zero();
        wait_done(++target);
        issue(rand256(), 0);
        wait_done(++target);
        // re-expansion from READY
        check("ready_before_restart", 128'(key_ready), 128'd1);
        issue(rand256(), 0);
        check("ready_drop", 128'(key_ready), 128'd0);
        check("busy_restart", 128'(busy), 128'd1);
        wait_done(++target);
        for (int n = 0; n < 6; n++) begin
            issue(rand256(), 0);
            wait_done(++target);
        end
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
